// File: rtl/video_scanout_if.sv
// Video RAM read port: registered byte address out, data byte returned one clock later.
interface video_scanout_if;
    logic [14:0] vram_addr;
    logic [7:0]  vram_data;

    modport master (output vram_addr, input vram_data);
    modport slave  (input vram_addr, output vram_data);
endinterface

// File: rtl/video_scanout.sv
// Raster timing generator with a 1-bpp bitmap window fetched from video RAM.
// Video outputs lag the (h,v) counters by two clocks.
module video_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int WIN_X    = 64,
    parameter int WIN_Y    = 69,
    parameter int WIN_W    = 512,
    parameter int WIN_H    = 342
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [14:0]     base_addr,
    input  logic            invert,
    video_scanout_if.master vram,
    output logic            pixel,
    output logic            de,
    output logic            hsync_n,
    output logic            vsync_n,
    output logic            frame_irq
);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] WIN_X0   = 10'(WIN_X);
    localparam logic [9:0] WIN_X1   = 10'(WIN_X + WIN_W);
    localparam logic [9:0] WIN_Y0   = 10'(WIN_Y);
    localparam logic [9:0] WIN_Y1   = 10'(WIN_Y + WIN_H);
    localparam logic [2:0] WIN_X_PH = 3'(WIN_X);

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [9:0]  h_nx, row, colf;
    logic        row_in, col_in, fetch;
    logic [14:0] base_l_q, base_l_d;
    logic [14:0] vram_addr_q, vram_addr_d;
    logic [7:0]  sr_q, sr_d;
    logic        de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, ld1_q, ld1_d, irq1_q, irq1_d;
    logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, irq_q, irq_d;

    always_comb begin
        h_nx = h_q + 10'd1;
        h_d  = (h_q == H_LAST) ? '0 : h_nx;
        v_d  = v_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end

        row    = v_q - WIN_Y0;
        colf   = h_nx - WIN_X0;
        row_in = (v_q >= WIN_Y0) && (v_q < WIN_Y1);
        col_in = (h_q >= WIN_X0) && (h_q < WIN_X1);

        // Address is registered a cycle ahead so it is valid during h = WIN_X + 8k.
        fetch = row_in && (h_nx >= WIN_X0) && (h_nx < WIN_X1) && (colf[2:0] == 3'd0);
        vram_addr_d = fetch ? (base_l_q + 15'({row, 6'd0}) + {8'd0, colf[9:3]})
                            : vram_addr_q;

        base_l_d = ((h_q == '0) && (v_q == V_ACT)) ? base_addr : base_l_q;

        de1_d  = (h_q < H_ACT) && (v_q < V_ACT);
        hs1_d  = !((h_q >= HS_START) && (h_q < HS_END));
        vs1_d  = !((v_q >= VS_START) && (v_q < VS_END));
        ld1_d  = row_in && col_in && (h_q[2:0] == WIN_X_PH);
        irq1_d = (h_q == '0) && (v_q == V_ACT);

        // Shift register doubles as the pixel output flop; zeros shifted in blank the border.
        sr_d = ld1_q ? (vram.vram_data ^ {8{invert}}) : {sr_q[6:0], 1'b0};

        de_d  = de1_q;
        hs_d  = hs1_q;
        vs_d  = vs1_q;
        irq_d = irq1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q         <= '0;
            v_q         <= '0;
            base_l_q    <= '0;
            vram_addr_q <= '0;
            sr_q        <= '0;
            de1_q       <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            ld1_q       <= 1'b0;
            irq1_q      <= 1'b0;
            de_q        <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            irq_q       <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            base_l_q    <= base_l_d;
            vram_addr_q <= vram_addr_d;
            sr_q        <= sr_d;
            de1_q       <= de1_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            ld1_q       <= ld1_d;
            irq1_q      <= irq1_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            irq_q       <= irq_d;
        end
    end

    assign vram.vram_addr = vram_addr_q;
    assign pixel          = sr_q[7];
    assign de             = de_q;
    assign hsync_n        = hs_q;
    assign vsync_n        = vs_q;
    assign frame_irq      = irq_q;
endmodule

// File: tb/tb_video_scanout.sv
// Bench for video_scanout: scaled-down timing instance checked by a scoreboard every cycle,
// plus a default-timing instance for line-level hsync/de measurements.
module tb_video_scanout;
    localparam int HA = 40, HF = 4, HS = 8, HB = 8, HT = HA + HF + HS + HB;
    localparam int VA = 30, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int WX = 8, WY = 4, WW = 16, WH = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] base_addr = '0;
    logic        invert = 1'b0;
    logic        pixel, de, hsync_n, vsync_n, frame_irq;
    logic        pixel0, de0, hs0, vs0, irq0;

    video_scanout_if vif ();
    video_scanout_if vif0 ();

    video_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .WIN_X(WX), .WIN_Y(WY), .WIN_W(WW), .WIN_H(WH)
    ) dut (
        .clk(clk), .reset(reset), .base_addr(base_addr), .invert(invert), .vram(vif),
        .pixel(pixel), .de(de), .hsync_n(hsync_n), .vsync_n(vsync_n), .frame_irq(frame_irq)
    );

    video_scanout dut0 (
        .clk(clk), .reset(reset), .base_addr(base_addr), .invert(invert), .vram(vif0),
        .pixel(pixel0), .de(de0), .hsync_n(hs0), .vsync_n(vs0), .frame_irq(irq0)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [32768];
    always @(posedge clk) begin
        vif.vram_data  <= ram[vif.vram_addr];
        vif0.vram_data <= ram[vif0.vram_addr];
    end

    typedef struct packed {
        int         h;
        int         v;
        logic [4:0] out;
    } exp_t;

    typedef struct {
        logic [14:0] base;
        logic [7:0]  data;
        logic        inv;
        logic [7:0]  pix;
    } vec_t;

    exp_t        sbq[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          hm = 0, vm = 0;
    logic [14:0] base_m = '0;
    logic [14:0] last_fetch = '0;
    bit          fetch_seen = 0;
    logic [7:0]  cap;
    logic [1:0]  border;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [4:0] model(input int h, input int v);
        logic        p;
        logic [7:0]  b;
        logic [14:0] a;
        int          r, c;
        p = 1'b0;
        r = v - WY;
        c = h - WX;
        if (r >= 0 && r < WH && c >= 0 && c < WW) begin
            a = 15'(int'(base_m) + r * 64 + c / 8);
            b = ram[a];
            p = b[7 - c % 8] ^ invert;
        end
        return {p, (h < HA && v < VA), !(h >= HA + HF && h < HA + HF + HS),
                !(v >= VA + VF && v < VA + VF + VS), (h == 0 && v == VA)};
    endfunction

    task automatic step();
        exp_t e;
        int   r, c;
        r = vm - WY;
        c = hm - WX;
        if (r >= 0 && r < WH && c >= 0 && c < WW && c % 8 == 0) begin
            check($sformatf("vram_addr r=%0d c=%0d", r, c), int'(vif.vram_addr),
                  (int'(base_m) + r * 64 + c / 8) & 32'h7fff);
            if (base_m == 15'h7F00 && r == 4 && c == 0)
                check("wrap_row4_addr", int'(vif.vram_addr), 0);
            last_fetch = vif.vram_addr;
            fetch_seen = 1;
        end
        if (hm == 0 && vm == VA) begin
            if (fetch_seen)
                check("last_fetch", int'(last_fetch),
                      (int'(base_m) + (WH - 1) * 64 + WW / 8 - 1) & 32'h7fff);
            fetch_seen = 0;
        end
        e.h   = hm;
        e.v   = vm;
        e.out = model(hm, vm);
        sbq.push_back(e);
        if (hm == 0 && vm == VA) base_m = base_addr;
        @(posedge clk);
        #1;
        hm++;
        if (hm == HT) begin
            hm = 0;
            vm++;
            if (vm == VT) vm = 0;
        end
        if (sbq.size() >= 2) begin
            e = sbq.pop_front();
            check($sformatf("video h=%0d v=%0d", e.h, e.v),
                  int'({pixel, de, hsync_n, vsync_n, frame_irq}), int'(e.out));
            if (e.v == WY && e.h >= WX && e.h < WX + 8) cap[7 - (e.h - WX)] = pixel;
            if (e.v == WY && e.h == WX - 1) border[0] = pixel;
            if (e.v == WY && e.h == WX + WW) border[1] = pixel;
        end
    endtask

    task automatic run_until(input int h, input int v);
        int budget;
        budget = 3 * HT * VT;
        while (!(hm == h && vm == v)) begin
            if (budget == 0) begin
                n_chk++;
                $display("FAIL run_until timeout: at h=%0d v=%0d, wanted h=%0d v=%0d", hm, vm, h, v);
                return;
            end
            budget--;
            step();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pixel"}, int'(pixel), 0);
        check({tag, " de"}, int'(de), 0);
        check({tag, " hsync_n"}, int'(hsync_n), 1);
        check({tag, " vsync_n"}, int'(vsync_n), 1);
        check({tag, " frame_irq"}, int'(frame_irq), 0);
        check({tag, " vram_addr"}, int'(vif.vram_addr), 0);
    endtask

    // Default-timing instance: first line measurements after the initial reset release.
    initial begin
        int   n, f1, f2, lowc, dec;
        logic prev;
        n = 0; f1 = -1; f2 = -1; lowc = 0; dec = 0; prev = 1'b1;
        @(negedge reset);
        repeat (2500) begin
            @(negedge clk);
            n++;
            if (prev && !hs0) begin
                if (f1 < 0) f1 = n;
                else if (f2 < 0) f2 = n;
            end
            if (f1 >= 0 && f2 < 0 && !hs0) lowc++;
            if (n <= 800 && de0) dec++;
            prev = hs0;
        end
        check("dflt first hsync fall", f1, 658);
        check("dflt hsync period", f2 - f1, 800);
        check("dflt hsync low width", lowc, 96);
        check("dflt de per line", dec, 640);
    end

    initial begin
        vec_t vt[4];
        vt[0] = '{15'h1000, 8'hA5, 1'b0, 8'b1010_0101};
        vt[1] = '{15'h1000, 8'hA5, 1'b1, 8'b0101_1010};
        vt[2] = '{15'h0234, 8'h3C, 1'b0, 8'b0011_1100};
        vt[3] = '{15'h7F00, 8'h81, 1'b1, 8'b0111_1110};

        for (int i = 0; i < 32768; i++) ram[i] = 8'($urandom);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        run_until(0, VA);
        for (int i = 0; i < 4; i++) begin
            run_until(0, WY + 5);
            base_addr        = vt[i].base;
            ram[vt[i].base]  = vt[i].data;
            invert           = vt[i].inv;
            cap              = ~vt[i].pix;
            border           = 2'b11;
            run_until(0, VA);
            run_until(WX + WW + 4, WY);
            check($sformatf("vec%0d row0 pixels", i), int'(cap), int'(vt[i].pix));
            check($sformatf("vec%0d left border", i), int'(border[0]), 0);
            check($sformatf("vec%0d right border", i), int'(border[1]), 0);
        end

        run_until(30, 20);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("midframe reset");
        sbq.delete();
        hm = 0;
        vm = 0;
        base_m = '0;
        fetch_seen = 0;
        base_addr = 15'h1234;
        invert = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_until(0, VA);
        run_until(WX + WW + 4, WY + 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
